run_timer_pr: RTL

Survival-time stopwatch with personal-record (PR) latch for the stay-on-road game. It sits downstream of `block_controller`, which runs on the slow `move_clk` domain. It consumes that block's `deadFlag` and counts elapsed run time in BCD centiseconds. On each death it freezes the count and updates the best (longest) time. It feeds the 8-digit SSD scan/decode stage: digits 7..4 show the current time, digits 3..0 show the PR.

---
 rtl/run_timer_pr.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/run_timer_pr.sv
// run_timer_pr -- survival-time stopwatch with personal-record latch.
//
// Counts elapsed run time in packed BCD centiseconds while the game is
// running, freezes the count when the player dies, and keeps the longest
// time seen since Reset.
//
// Ports:
//   ClkPort   system clock, all logic on its rising edge
//   Reset     asynchronous, active-high; clears everything including the PR
//   dead      death flag from the move_clk domain (asynchronous)
//   restart   debounced button level (asynchronous); rising edge restarts
//   cur_bcd   current time {s10, s1, cs10, cs1}
//   pr_bcd    best time, same format
//   pr_valid  at least one run has ended since Reset
//   running   timer is in the RUN state
//   new_pr    one-cycle pulse when pr_bcd was just updated
module run_timer_pr #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        dead,
    input  logic        restart,
    output logic [15:0] cur_bcd,
    output logic [15:0] pr_bcd,
    output logic        pr_valid,
    output logic        running,
    output logic        new_pr
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]   BCD_MAX   = 16'h9999;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          d_s1, d_s2, d_s3;
    logic          r_s1, r_s2, r_s3;
    logic [PW-1:0] presc, presc_nxt;
    logic [15:0]   cur_nxt, pr_nxt;
    logic          pr_valid_nxt, new_pr_nxt;
    logic          dead_rise, rst_rise, tick;

    // Packed-BCD +1 with per-digit carry; caller handles saturation.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            d_s1 <= 1'b0;
            d_s2 <= 1'b0;
            d_s3 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            d_s1 <= dead;
            d_s2 <= d_s1;
            d_s3 <= d_s2;
            r_s1 <= restart;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign dead_rise = d_s2 & ~d_s3;
    assign rst_rise  = r_s2 & ~r_s3;
    assign tick      = (state == RUN) && (presc == PRESC_MAX);

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state    <= RUN;
            presc    <= '0;
            cur_bcd  <= '0;
            pr_bcd   <= '0;
            pr_valid <= 1'b0;
            new_pr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            cur_bcd  <= cur_nxt;
            pr_bcd   <= pr_nxt;
            pr_valid <= pr_valid_nxt;
            new_pr   <= new_pr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        presc_nxt    = presc;
        cur_nxt      = cur_bcd;
        pr_nxt       = pr_bcd;
        pr_valid_nxt = pr_valid;
        new_pr_nxt   = 1'b0;
        case (state)
            RUN: begin
                if (dead_rise) begin
                    // Death beats a coincident tick: freeze and compare the
                    // pre-tick value. Unsigned compare orders packed BCD.
                    state_nxt    = DEAD;
                    presc_nxt    = '0;
                    pr_valid_nxt = 1'b1;
                    if (!pr_valid || (cur_bcd > pr_bcd)) begin
                        pr_nxt     = cur_bcd;
                        new_pr_nxt = 1'b1;
                    end
                end else begin
                    presc_nxt = tick ? '0 : presc + PW'(1);
                    if (tick && (cur_bcd != BCD_MAX))
                        cur_nxt = bcd_inc(cur_bcd);
                end
            end
            DEAD: begin
                presc_nxt = '0;
                // A restart while death is still asserted is dropped.
                if (rst_rise && !d_s2) begin
                    state_nxt = RUN;
                    cur_nxt   = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign running = (state == RUN);

endmodule
